// File: rtl/game_countdown_timer.sv
// Round countdown timer: two-digit BCD count from START_SEC driven by one_sec ticks.
// Optional feature macro TIME_BONUS_EN adds the bonus_i port and BONUS_SEC adder.
module game_countdown_timer #(
  parameter int START_SEC = 60,
  parameter int WARN_SEC  = 10
`ifdef TIME_BONUS_EN
  ,
  parameter int BONUS_SEC = 5
`endif
) (
  input  logic       clk_i,
  input  logic       resetN_i,
  input  logic       one_sec_i,
  input  logic       start_i,
  input  logic       pause_i,
`ifdef TIME_BONUS_EN
  input  logic       bonus_i,
`endif
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       running_o,
  output logic       warning_o,
  output logic       time_up_o,
  output logic       expired_o
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, EXPIRED} state_e;

  localparam logic [6:0] START_VAL  = 7'(START_SEC);
  localparam logic [6:0] WARN_VAL   = 7'(WARN_SEC);
  localparam logic [3:0] START_TENS = 4'(START_SEC / 10);
  localparam logic [3:0] START_UNIT = 4'(START_SEC % 10);

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       warning_q, warning_d;
  logic       time_up_q, time_up_d;
  logic [6:0] curVal;
  logic [6:0] nextVal;

  // Arithmetic is done on the binary value of the two digits and split back into BCD.
  assign curVal = 7'(tens_q) * 7'd10 + 7'(units_q);

`ifdef TIME_BONUS_EN
  logic       tickTaken;
  logic [7:0] bonusSum;
  logic [6:0] bonusVal;

  assign tickTaken = (state_q == RUN) && one_sec_i;
  assign bonusSum  = {1'b0, curVal} + 8'(BONUS_SEC) - {7'd0, tickTaken};
  assign bonusVal  = (bonusSum > 8'd99) ? 7'd99 : bonusSum[6:0];
`endif

  always_comb begin
    state_d   = state_q;
    nextVal   = curVal;
    time_up_d = 1'b0;
    unique case (state_q)
      IDLE, EXPIRED: begin
        if (start_i) begin
          state_d = RUN;
          nextVal = START_VAL;
        end
      end
      RUN: begin
        if (start_i) begin
          nextVal = START_VAL;
        end else if (pause_i) begin
          state_d = HOLD;
        end else
`ifdef TIME_BONUS_EN
        if (bonus_i) begin
          nextVal = bonusVal;
        end else
`endif
        if (one_sec_i && (curVal != 7'd0)) begin
          nextVal = curVal - 7'd1;
          if (curVal == 7'd1) begin
            state_d   = EXPIRED;
            time_up_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (start_i) begin
          state_d = RUN;
          nextVal = START_VAL;
        end else begin
`ifdef TIME_BONUS_EN
          if (bonus_i) nextVal = bonusVal;
`endif
          if (!pause_i) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    tens_d    = 4'(nextVal / 7'd10);
    units_d   = 4'(nextVal % 7'd10);
    warning_d = ((state_d == RUN) || (state_d == HOLD)) && (nextVal <= WARN_VAL);
  end

  always_ff @(posedge clk_i) begin
    if (!resetN_i) begin
      state_q   <= IDLE;
      tens_q    <= START_TENS;
      units_q   <= START_UNIT;
      warning_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      warning_q <= warning_d;
      time_up_q <= time_up_d;
    end
  end

  assign tens_o    = tens_q;
  assign units_o   = units_q;
  assign running_o = (state_q == RUN);
  assign expired_o = (state_q == EXPIRED);
  assign warning_o = warning_q;
  assign time_up_o = time_up_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Testbench for game_countdown_timer: directed scenarios plus random traffic vs. a seconds-level model.
module tb_game_countdown_timer;

  localparam int START = 60;
  localparam int WARN  = 10;
  localparam int BONUS = 5;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_EXP  = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       oneSec = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       bonus = 1'b0;
  logic [3:0] tens, units;
  logic       running, warning, timeUp, expired;

  int checks = 0;
  int failures = 0;
  int modelRem = START;
  int modelMode = M_IDLE;
  bit modelTimeUp = 1'b0;

  game_countdown_timer dut (
    .clk_i     (clk),
    .resetN_i  (resetN),
    .one_sec_i (oneSec),
    .start_i   (start),
    .pause_i   (pause),
`ifdef TIME_BONUS_EN
    .bonus_i   (bonus),
`endif
    .tens_o    (tens),
    .units_o   (units),
    .running_o (running),
    .warning_o (warning),
    .time_up_o (timeUp),
    .expired_o (expired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Seconds-level behaviour of one clock cycle, from the round rules.
  task automatic modelStep(input bit rn, input bit st, input bit pa, input bit os, input bit bo);
    int delta;
    bit bonusOn;
`ifdef TIME_BONUS_EN
    bonusOn = 1'b1;
`else
    bonusOn = 1'b0;
`endif
    modelTimeUp = 1'b0;
    if (!rn) begin
      modelMode = M_IDLE;
      modelRem  = START;
    end else if (modelMode == M_IDLE || modelMode == M_EXP) begin
      if (st) begin
        modelMode = M_RUN;
        modelRem  = START;
      end
    end else if (st) begin
      modelMode = M_RUN;
      modelRem  = START;
    end else if (modelMode == M_RUN && pa) begin
      modelMode = M_HOLD;
    end else begin
      delta = 0;
      if (bonusOn && bo) delta += BONUS;
      if (modelMode == M_RUN && os) delta -= 1;
      modelRem += delta;
      if (modelRem > 99) modelRem = 99;
      if (modelMode == M_HOLD && !pa) modelMode = M_RUN;
      if (modelMode == M_RUN && modelRem == 0) begin
        modelMode   = M_EXP;
        modelTimeUp = 1'b1;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".tens"}, int'(tens), modelRem / 10);
    checkOutput({tag, ".units"}, int'(units), modelRem % 10);
    checkOutput({tag, ".running"}, int'(running), int'(modelMode == M_RUN));
    checkOutput({tag, ".warning"}, int'(warning),
                int'((modelMode == M_RUN || modelMode == M_HOLD) && modelRem <= WARN));
    checkOutput({tag, ".time_up"}, int'(timeUp), int'(modelTimeUp));
    checkOutput({tag, ".expired"}, int'(expired), int'(modelMode == M_EXP));
  endtask

  task automatic applyStimulus(input string tag, input bit rn, input bit st, input bit pa,
                               input bit os, input bit bo);
    @(negedge clk);
    resetN = rn;
    start  = st;
    pause  = pa;
    oneSec = os;
    bonus  = bo;
    @(posedge clk);
    modelStep(rn, st, pa, os, bo);
    #1;
    checkAll(tag);
  endtask

  task automatic ticks(input string tag, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int g = 0; g < gap; g++) applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  function automatic int shown();
    return int'(tens) * 10 + int'(units);
  endfunction

  initial begin
    applyStimulus("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst.tens_const", int'(tens), 6);
    checkOutput("rst.units_const", int'(units), 0);
    applyStimulus("idle_tick", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_tick.value", shown(), 60);

    applyStimulus("cd.start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("cd", 59, 3);
    applyStimulus("cd.last", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("cd.time_up_pulse", int'(timeUp), 1);
    applyStimulus("cd.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cd.time_up_drop", int'(timeUp), 0);
    checkOutput("cd.expired", int'(expired), 1);
    ticks("cd.hold00", 3, 1);
    checkOutput("cd.stay00", shown(), 0);

    applyStimulus("pz.start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("pz", 15, 1);
    checkOutput("pz.at45", shown(), 45);
    for (int i = 0; i < 12; i++)
      applyStimulus("pz.hold", 1'b1, 1'b0, 1'b1, (i % 4) == 0, 1'b0);
    checkOutput("pz.still45", shown(), 45);
    applyStimulus("pz.release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("pz.tick", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pz.at44", shown(), 44);
    applyStimulus("pz.both", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("pz.both44", shown(), 44);
    applyStimulus("pz.release2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    ticks("rs", 21, 0);
    checkOutput("rs.at23", shown(), 23);
    applyStimulus("rs.restart", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rs.at60", shown(), 60);
    ticks("rs.run", 60, 0);
    applyStimulus("rs.expstart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rs.exp_cleared", int'(expired), 0);
    checkOutput("rs.exp_running", int'(running), 1);

`ifdef TIME_BONUS_EN
    ticks("bn", 52, 0);
    checkOutput("bn.at08", shown(), 8);
    applyStimulus("bn.add", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bn.at13", shown(), 13);
    checkOutput("bn.warn_off", int'(warning), 0);
    applyStimulus("bn.restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("bn", 30, 0);
    applyStimulus("bn.both", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("bn.at34", shown(), 34);
    applyStimulus("bn.restart2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("bn", 3, 0);
    for (int i = 0; i < 8; i++) applyStimulus("bn.up", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bn.at97", shown(), 97);
    applyStimulus("bn.sat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bn.at99", shown(), 99);
    applyStimulus("bn.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("bn.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bn.idle60", shown(), 60);
`endif

    applyStimulus("mr.start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("mr", 43, 0);
    applyStimulus("mr.pause", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mr.at17", shown(), 17);
    applyStimulus("mr.reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("mr.digits60", shown(), 60);
    checkOutput("mr.running0", int'(running), 0);
    checkOutput("mr.expired0", int'(expired), 0);

    begin
      bit pz = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(14) == 0) pz = ~pz;
        applyStimulus("rnd", $urandom_range(499) != 0, $urandom_range(299) == 0, pz,
                      $urandom_range(1) == 0, $urandom_range(24) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
